// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl -- read-side control of the asynchronous FIFO (read clock domain).
//
// Decodes the synchronized Gray write pointer to binary, advances the binary
// read pointer on accepted reads, and registers empty / underflow status.
// With `FIFO_RD_LEVEL_EN defined it also registers the fill level and an
// almost-empty flag. Without it, rd_level is tied to 0 and almost_empty
// follows empty, so the port list is the same in both builds.
//
// Ports:
//   clk          read-domain clock
//   reset        synchronous, active-high reset
//   rd_en        read request from the consumer
//   wq2_gray     synchronized Gray-coded write pointer (ADDR_W+1 bits)
//   rd_ptr       registered binary read pointer (to the read->write synchronizer)
//   rd_addr      RAM read address, rd_ptr[ADDR_W-1:0]
//   rd_fire      combinational accepted read, rd_en & ~empty
//   empty        registered empty flag
//   underflow    registered one-cycle pulse per rejected read
//   rd_level     registered occupancy 0..2**ADDR_W (level build only)
//   almost_empty registered rd_level <= AE_THRESH (level build only)
module fifo_rd_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   wq2_gray,
  output logic [ADDR_W:0]   rd_ptr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_fire,
  output logic              empty,
  output logic              underflow,
  output logic [ADDR_W:0]   rd_level,
  output logic              almost_empty
);

  localparam int              PW     = ADDR_W + 1;
  localparam logic [PW-1:0]   DEPTH  = PW'(2 ** ADDR_W);
  localparam logic [PW-1:0]   AE_LIM = PW'(AE_THRESH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // A distance above the depth only arises from incoherent pointers; clamp it.
  function automatic logic [PW-1:0] sat_level(input logic [PW-1:0] diff);
    if (diff > DEPTH) return DEPTH;
    else              return diff;
  endfunction

  logic [PW-1:0] wbin;
  logic [PW-1:0] rd_ptr_nxt;

  assign wbin       = gray2bin(wq2_gray);
  assign rd_fire    = rd_en & ~empty;
  assign rd_ptr_nxt = rd_ptr + PW'(rd_fire);
  assign rd_addr    = rd_ptr[ADDR_W-1:0];

  // Comparing against the next pointer makes empty rise on the same edge
  // that consumes the last entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      empty     <= 1'b1;
      underflow <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr_nxt;
      empty     <= (rd_ptr_nxt == wbin);
      underflow <= rd_en & empty;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [PW-1:0] level_nxt;

  assign level_nxt = sat_level(wbin - rd_ptr_nxt);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_level     <= '0;
      almost_empty <= 1'b1;
    end else begin
      rd_level     <= level_nxt;
      almost_empty <= (level_nxt <= AE_LIM);
    end
  end
`else
  // AE_THRESH and the saturation helper have no effect without the level logic.
  logic [PW-1:0] unused_level;

  assign unused_level = AE_LIM ^ sat_level('0);
  assign rd_level     = '0;
  assign almost_empty = empty;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Testbench for fifo_rd_ctrl: directed per-cycle vectors feed a scoreboard
// queue; a monitor on the falling edge pops and compares each entry.
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rd_en;
  logic [4:0] wq2_gray;
  logic [4:0] rd_ptr;
  logic [3:0] rd_addr;
  logic       rd_fire;
  logic       empty;
  logic       underflow;
  logic [4:0] rd_level;
  logic       almost_empty;

  fifo_rd_ctrl #(.ADDR_W(4), .AE_THRESH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .rd_en        (rd_en),
    .wq2_gray     (wq2_gray),
    .rd_ptr       (rd_ptr),
    .rd_addr      (rd_addr),
    .rd_fire      (rd_fire),
    .empty        (empty),
    .underflow    (underflow),
    .rd_level     (rd_level),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  // Registered fields hold the values produced by the previous edge;
  // fire is the combinational response to this cycle's inputs. -1 = don't care.
  typedef struct {
    string name;
    int    ptr;
    int    emp;
    int    uf;
    int    lvl;
    int    fire;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string nm, input string fld, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s.%s: got %0d required %0d", nm, fld, act, req);
  endtask

  task automatic cyc(input string nm, input int rst, input int en, input int wb,
                     input int ptr, input int emp, input int uf, input int lvl,
                     input int fire);
    exp_t e;
    @(posedge clk);
    #2;
    reset    = (rst != 0);
    rd_en    = (en != 0);
    wq2_gray = gray(wb);
    e.name = nm; e.ptr = ptr; e.emp = emp; e.uf = uf; e.lvl = lvl; e.fire = fire;
    exp_q.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      int   ae_req;
      e = exp_q.pop_front();
      if (e.ptr >= 0) begin
        chk(e.name, "rd_ptr", int'(rd_ptr), e.ptr);
        chk(e.name, "rd_addr", int'(rd_addr), e.ptr % 16);
      end
      if (e.emp >= 0)  chk(e.name, "empty", int'(empty), e.emp);
      if (e.uf >= 0)   chk(e.name, "underflow", int'(underflow), e.uf);
      if (e.fire >= 0) chk(e.name, "rd_fire", int'(rd_fire), e.fire);
`ifdef FIFO_RD_LEVEL_EN
      if (e.lvl >= 0) begin
        chk(e.name, "rd_level", int'(rd_level), e.lvl);
        ae_req = (e.lvl <= 2) ? 1 : 0;
        chk(e.name, "almost_empty", int'(almost_empty), ae_req);
      end
`else
      if (e.lvl >= 0) chk(e.name, "rd_level", int'(rd_level), 0);
      if (e.emp >= 0) begin
        ae_req = e.emp;
        chk(e.name, "almost_empty", int'(almost_empty), ae_req);
      end
`endif
    end
  end

  initial begin
    reset    = 1'b1;
    rd_en    = 1'b0;
    wq2_gray = 5'd0;

    //        name       rst en wb  ptr emp uf lvl fire
    cyc("rst_a",         1, 1, 0,   0,  1,  0, 0,  0);
    cyc("rst_b",         0, 0, 0,   0,  1,  0, 0,  0);
    cyc("wr4_drive",     0, 0, 4,   0,  1,  0, 0,  0);
    cyc("rd0",           0, 1, 4,   0,  0,  0, 4,  1);
    cyc("rd1",           0, 1, 4,   1,  0,  0, 3,  1);
    cyc("rd2",           0, 1, 4,   2,  0,  0, 2,  1);
    cyc("rd3",           0, 1, 4,   3,  0,  0, 1,  1);
    cyc("rd_empty",      0, 1, 4,   4,  1,  0, 0,  0);
    cyc("uf_1",          0, 1, 4,   4,  1,  1, 0,  0);
    cyc("uf_2",          0, 0, 4,   4,  1,  1, 0,  0);
    cyc("uf_done",       0, 0, 4,   4,  1,  0, 0,  0);

    // Advance the write pointer one Gray step per cycle while reading behind it,
    // ending with rd_ptr = 30 and wbin = 2.
    for (int i = 0; i < 30; i++) begin
      cyc("advance", 0, (i > 0 && i < 27) ? 1 : 0, (5 + i) % 32, -1, -1, -1, -1, -1);
    end

    cyc("wrap30",        0, 1, 2,  30,  0,  0, 4,  1);
    cyc("wrap31",        0, 1, 2,  31,  0,  0, 3,  1);
    cyc("wrap0",         0, 1, 2,   0,  0,  0, 2,  1);
    cyc("wrap1",         0, 1, 2,   1,  0,  0, 1,  1);
    cyc("wrap_empty",    0, 0, 2,   2,  1,  0, 0,  0);

    // Reset, then bring the write pointer up to 16 one step at a time.
    cyc("rst_c",         1, 0, 3,   2,  1,  0, 0,  0);
    for (int b = 4; b <= 16; b++) begin
      cyc("fill", 0, 0, b, -1, -1, -1, -1, -1);
    end

    cyc("full",          0, 0, 16,  0,  0,  0, 16, 0);
    cyc("full_rd0",      0, 1, 16,  0,  0,  0, 16, 1);
    cyc("full_rd1",      0, 1, 16,  1,  0,  0, 15, 1);
    cyc("mid_rst",       1, 1, 16,  2,  0,  0, 14, 1);
    cyc("post_rst",      0, 0, 16,  0, -1,  0, 0,  0);
    cyc("post_rst2",     0, 0, 16,  0,  0,  0, 16, 0);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
